// File: rtl/hex7seg_scan_driver.sv
// Time-multiplexed hex display driver: latches DIGITS nibbles and scans them onto a
// common-segment, per-digit-anode 7-segment display with guard, blanking and LZ suppression.
module hex7seg_scan_driver #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned CLK_DIV        = 8,
    parameter int unsigned GUARD          = 2,
    parameter bit          ACTIVE_LOW_SEG = 1'b1,
    parameter bit          ACTIVE_LOW_AN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0]        SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = ACTIVE_LOW_SEG ? 1'b1 : 1'b0;
    localparam logic [DIGITS-1:0] AN_OFF  = ACTIVE_LOW_AN ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] sh_val_q, sh_val_d;
    logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_done_q, frame_done_d;

    logic in_guard;

    // With GUARD=0 the comparison would be constant-false, so elide it entirely.
    if (GUARD == 0) begin : g_no_guard
        assign in_guard = 1'b0;
    end else begin : g_guard
        assign in_guard = (pcnt_q < PW'(GUARD));
    end

    // Scan timing and shadow registers.
    always_comb begin
        pcnt_d       = pcnt_q + PW'(1);
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        if (pcnt_q == PW'(CLK_DIV - 1)) begin
            pcnt_d = '0;
            if (idx_q == IW'(DIGITS - 1)) begin
                idx_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end

        sh_val_d   = load ? value      : sh_val_q;
        sh_blank_d = load ? blank_mask : sh_blank_q;
        sh_dp_d    = load ? dp_mask    : sh_dp_q;
    end

    logic [3:0]        cur_nib;
    logic              cur_blank;
    logic              cur_dp;
    logic              cur_lz;
    logic [DIGITS-1:0] onehot;
    logic [DIGITS-1:0] lz_dark;
    logic              all_zero;
    logic              dark;

    // Display output generation from the current scan position.
    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        cur_lz    = 1'b0;
        onehot    = '0;
        lz_dark   = '0;
        all_zero  = 1'b1;

        // Walk from the top digit down: a digit is a leading zero if it and all above are zero.
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            all_zero   = all_zero & (sh_val_q[4*i +: 4] == 4'h0);
            lz_dark[i] = lz_blank & all_zero & (i != 0);
        end

        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = sh_val_q[4*i +: 4];
                cur_blank = sh_blank_q[i];
                cur_dp    = sh_dp_q[i];
                cur_lz    = lz_dark[i];
                onehot[i] = 1'b1;
            end
        end

        dark = in_guard | cur_blank | cur_lz;

        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        an_d  = AN_OFF;
        if (!dark) begin
            seg_d = ACTIVE_LOW_SEG ? ~hex_decode(cur_nib) : hex_decode(cur_nib);
            dp_d  = ACTIVE_LOW_SEG ? ~cur_dp : cur_dp;
            an_d  = ACTIVE_LOW_AN ? ~onehot : onehot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q       <= '0;
            idx_q        <= '0;
            sh_val_q     <= '0;
            sh_blank_q   <= '0;
            sh_dp_q      <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            sh_val_q     <= sh_val_d;
            sh_blank_q   <= sh_blank_d;
            sh_dp_q      <= sh_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex7seg_scan_driver.sv
// Scoreboard bench for hex7seg_scan_driver: a cycle-count reference model predicts every
// registered output; a negedge monitor pops and compares.
module tb_hex7seg_scan_driver;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned CLK_DIV = 8;
    localparam int unsigned GUARD   = 2;
    localparam int unsigned FRAME   = DIGITS * CLK_DIV;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [3:0]  dp_mask;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    hex7seg_scan_driver #(
        .DIGITS         (DIGITS),
        .CLK_DIV        (CLK_DIV),
        .GUARD          (GUARD),
        .ACTIVE_LOW_SEG (1'b1),
        .ACTIVE_LOW_AN  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t q[$];

    // Model state: edges since reset release plus the latched display contents.
    int unsigned n;
    logic [15:0] m_val;
    logic [3:0]  m_blank;
    logic [3:0]  m_dp;
    logic [6:0]  dec_tbl [16];

    initial begin
        dec_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    end

    function automatic exp_t model_out();
        exp_t        e;
        int unsigned pc;
        int unsigned ix;
        logic [15:0] upper;
        logic [3:0]  nib;
        logic        dark;
        pc    = n % CLK_DIV;
        ix    = (n / CLK_DIV) % DIGITS;
        upper = m_val >> (4 * ix);
        nib   = upper[3:0];
        dark  = (pc < GUARD) || m_blank[ix] || (lz_blank && ix != 0 && upper == 16'h0);
        if (dark) begin
            e.an  = 4'hF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end else begin
            e.an  = ~(4'b0001 << ix);
            e.seg = ~dec_tbl[nib];
            e.dp  = ~m_dp[ix];
        end
        e.fd = ((n + 1) % FRAME) == 0;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        q.push_back(model_out());
        if (load) begin
            m_val   = value;
            m_blank = blank_mask;
            m_dp    = dp_mask;
        end
        n++;
        #1;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic load_once(input logic [15:0] v, input logic [3:0] bm, input logic [3:0] dm);
        value      = v;
        blank_mask = bm;
        dp_mask    = dm;
        load       = 1'b1;
        step();
        load       = 1'b0;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s: got an=%h seg=%h dp=%b fd=%b, want an=f seg=7f dp=1 fd=0",
                     name, an, seg, dp, frame_done);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({an, seg, dp, frame_done} !== e) begin
                errors++;
                $display("FAIL scan @%0t: got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=%b fd=%b",
                         $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
        end
    end

    task automatic model_reset();
        n       = 0;
        m_val   = '0;
        m_blank = '0;
        m_dp    = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        load       = 1'b1;
        value      = 16'hFFFF;
        blank_mask = 4'h0;
        dp_mask    = 4'hF;
        lz_blank   = 1'b0;
        model_reset();
        #12;
        check_idle("reset_hold");
        @(posedge clk);
        #1;
        check_idle("reset_hold_edge");
        load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_idle("after_release");

        // First frame with the cleared shadow, then a fixed pattern.
        run(FRAME);
        load_once(16'h1234, 4'h0, 4'h0);
        run(2 * FRAME);

        // Decode sweep on digit 0.
        for (int k = 0; k < 16; k++) begin
            load_once(16'(k), 4'h0, 4'h0);
            run(CLK_DIV);
        end

        // Leading-zero suppression.
        lz_blank = 1'b1;
        load_once(16'h0050, 4'h0, 4'h0);
        run(FRAME);
        load_once(16'h0000, 4'h0, 4'h0);
        run(FRAME);
        lz_blank = 1'b0;

        // Per-digit blanking and decimal point.
        load_once(16'hA7C3, 4'b0100, 4'b0001);
        run(FRAME);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            load       = ($urandom % 4) == 0;
            value      = 16'($urandom);
            blank_mask = 4'($urandom);
            dp_mask    = 4'($urandom);
            if (($urandom % 16) == 0) lz_blank = ~lz_blank;
            // Bias towards leading-zero-rich values so suppression is exercised.
            if (($urandom % 3) == 0) value = value >> (4 * ($urandom % 4));
            step();
        end
        load       = 1'b0;
        lz_blank   = 1'b0;

        // Asynchronous reset in the middle of digit 2's lit window.
        for (int i = 0; i < int'(FRAME); i++) begin
            if ((n % FRAME) == 2 * CLK_DIV + 4) break;
            step();
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        model_reset();
        @(negedge clk);
        #1;
        check_idle("async_reset_hold");
        rst_n = 1'b1;
        lz_blank = 1'b1;
        run(2 * FRAME);

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
